// File: rtl/branch_resolve.sv
//------------------------------------------------------------------------------
// Module      : branch_resolve
// Description : In-order prediction queue that checks LUT predictions against
//               execute outcomes, raises mispredict flushes and updates the LUT.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module branch_resolve #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH       = 8,
    parameter int CTR_ENTRIES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pred_push,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    input  logic                  pred_taken,
    input  logic [ADDR_WIDTH-1:0] pred_target,
    output logic                  pred_full,
    input  logic                  res_valid,
    input  logic                  res_is_branch,
    input  logic                  res_taken,
    input  logic [ADDR_WIDTH-1:0] res_target,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] flush_pc,
    output logic                  lut_write,
    output logic [ADDR_WIDTH-1:0] lut_write_key,
    output logic [ADDR_WIDTH-1:0] lut_write_val,
    output logic                  lut_hit,
    output logic                  qerr
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(CTR_ENTRIES);
    localparam logic [PW:0]     C_DEPTH = (PW+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem     [DEPTH];
    logic                  taken_mem  [DEPTH];
    logic [ADDR_WIDTH-1:0] target_mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [1:0]    ctr_q [CTR_ENTRIES];
    logic [1:0]    ctr_d [CTR_ENTRIES];

    logic                  flush_q, flush_d, lut_write_q, lut_write_d;
    logic                  lut_hit_q, lut_hit_d, qerr_q, qerr_d;
    logic [ADDR_WIDTH-1:0] flush_pc_q, flush_pc_d, key_q, key_d, val_q, val_d;

    logic                  e_taken, do_pop, is_full, br_taken, mispredict, push_ok;
    logic [ADDR_WIDTH-1:0] e_pc, e_target, correct_pc;
    logic [CW-1:0]         ctr_idx;
    logic [1:0]            ctr_cur, ctr_new;

    always_comb begin
        e_pc     = pc_mem[rd_ptr_q];
        e_taken  = taken_mem[rd_ptr_q];
        e_target = target_mem[rd_ptr_q];
        do_pop   = res_valid && (count_q != '0);
        is_full  = (count_q == C_DEPTH);
        br_taken = res_is_branch && res_taken;

        // A non-branch predicted taken means the LUT entry is stale or aliased.
        if (res_is_branch)
            mispredict = do_pop && ((e_taken != res_taken) ||
                                    (res_taken && (e_target != res_target)));
        else
            mispredict = do_pop && e_taken;
        correct_pc = br_taken ? res_target : e_pc + ADDR_WIDTH'(1);

        ctr_idx = e_pc[CW-1:0];
        ctr_cur = ctr_q[ctr_idx];
        if (res_taken)
            ctr_new = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
        else
            ctr_new = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;
        ctr_d = ctr_q;
        if (do_pop && res_is_branch)
            ctr_d[ctr_idx] = ctr_new;

        // Younger entries belong to the wrong path once a mispredict pops.
        push_ok = pred_push && !mispredict && (!is_full || do_pop);
        if (mispredict) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(do_pop);
            wr_ptr_d = wr_ptr_q + PW'(push_ok);
            count_d  = count_q + (PW+1)'(push_ok) - (PW+1)'(do_pop);
        end

        qerr_d      = qerr_q || (res_valid && (count_q == '0)) ||
                      (pred_push && is_full && !do_pop);
        flush_d     = mispredict;
        flush_pc_d  = mispredict ? correct_pc : '0;
        lut_write_d = do_pop && (res_is_branch || e_taken);
        key_d       = lut_write_d ? e_pc : '0;
        val_d       = !lut_write_d ? '0 : (br_taken ? res_target : e_target);
        lut_hit_d   = do_pop && res_is_branch && ctr_new[1];
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem[wr_ptr_q]     <= pred_pc;
            taken_mem[wr_ptr_q]  <= pred_taken;
            target_mem[wr_ptr_q] <= pred_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < CTR_ENTRIES; i++) ctr_q[i] <= 2'b01;
            flush_q     <= 1'b0;
            flush_pc_q  <= '0;
            lut_write_q <= 1'b0;
            key_q       <= '0;
            val_q       <= '0;
            lut_hit_q   <= 1'b0;
            qerr_q      <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ctr_q       <= ctr_d;
            flush_q     <= flush_d;
            flush_pc_q  <= flush_pc_d;
            lut_write_q <= lut_write_d;
            key_q       <= key_d;
            val_q       <= val_d;
            lut_hit_q   <= lut_hit_d;
            qerr_q      <= qerr_d;
        end
    end

    assign pred_full     = (count_q == C_DEPTH);
    assign flush         = flush_q;
    assign flush_pc      = flush_pc_q;
    assign lut_write     = lut_write_q;
    assign lut_write_key = key_q;
    assign lut_write_val = val_q;
    assign lut_hit       = lut_hit_q;
    assign qerr          = qerr_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
//------------------------------------------------------------------------------
// Module      : tb_branch_resolve
// Description : Scoreboard bench for branch_resolve with directed vectors.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_branch_resolve;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          pred_push, pred_taken, pred_full;
    logic [AW-1:0] pred_pc, pred_target;
    logic          res_valid, res_is_branch, res_taken;
    logic [AW-1:0] res_target;
    logic          flush, lut_write, lut_hit, qerr;
    logic [AW-1:0] flush_pc, lut_write_key, lut_write_val;

    branch_resolve #(.ADDR_WIDTH(AW), .DEPTH(8), .CTR_ENTRIES(16)) dut (
        .clk(clk), .reset(reset),
        .pred_push(pred_push), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_full(pred_full),
        .res_valid(res_valid), .res_is_branch(res_is_branch), .res_taken(res_taken),
        .res_target(res_target), .flush(flush), .flush_pc(flush_pc),
        .lut_write(lut_write), .lut_write_key(lut_write_key),
        .lut_write_val(lut_write_val), .lut_hit(lut_hit), .qerr(qerr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic          f;
        logic [AW-1:0] fpc;
        logic          lw;
        logic [AW-1:0] key;
        logic [AW-1:0] val;
        logic          hit;
    } exp_t;

    exp_t     sb[$];
    int       cyc = 0;
    int       tests = 0;
    int       fails = 0;
    logic [1:0] ctr_m [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Independent saturating-counter model; returns the new predict-taken bit.
    function automatic logic upd(input logic [AW-1:0] pc, input logic tk);
        logic [1:0] c;
        c = ctr_m[pc[3:0]];
        if (tk) c = (c == 2'd3) ? 2'd3 : c + 2'd1;
        else    c = (c == 2'd0) ? 2'd0 : c - 2'd1;
        ctr_m[pc[3:0]] = c;
        return c[1];
    endfunction

    task automatic exp_out(input logic f, input logic [AW-1:0] fpc, input logic lw,
                           input logic [AW-1:0] key, input logic [AW-1:0] val, input logic hit);
        exp_t e;
        e.due = cyc + 1; e.f = f; e.fpc = fpc; e.lw = lw; e.key = key; e.val = val; e.hit = hit;
        sb.push_back(e);
    endtask

    task automatic cyc_in(input logic push, input logic [AW-1:0] pc, input logic tk,
                          input logic [AW-1:0] tg, input logic rv, input logic br,
                          input logic rt, input logic [AW-1:0] rtg);
        pred_push = push; pred_pc = pc; pred_taken = tk; pred_target = tg;
        res_valid = rv; res_is_branch = br; res_taken = rt; res_target = rtg;
        @(posedge clk);
        #1;
        pred_push = 1'b0; res_valid = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic tk, input logic [AW-1:0] tg);
        cyc_in(1'b1, pc, tk, tg, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic pop(input logic br, input logic rt, input logic [AW-1:0] rtg);
        cyc_in(1'b0, '0, 1'b0, '0, 1'b1, br, rt, rtg);
    endtask

    // Monitor: compares against the scoreboard whenever an output is due or appears.
    always @(negedge clk) begin
        if (reset) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("flush",     {31'd0, flush},        {31'd0, e.f});
                chk("flush_pc",  {16'd0, flush_pc},     {16'd0, e.fpc});
                chk("lut_write", {31'd0, lut_write},    {31'd0, e.lw});
                chk("lut_key",   {16'd0, lut_write_key},{16'd0, e.key});
                chk("lut_val",   {16'd0, lut_write_val},{16'd0, e.val});
                chk("lut_hit",   {31'd0, lut_hit},      {31'd0, e.hit});
            end else if (flush || lut_write) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: flush=%0b lut_write=%0b key=%0h, required none",
                         flush, lut_write, lut_write_key);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) ctr_m[i] = 2'd1;
        reset = 1'b0;
        pred_push = 0; pred_pc = '0; pred_taken = 0; pred_target = '0;
        res_valid = 0; res_is_branch = 0; res_taken = 0; res_target = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_lut_write", {31'd0, lut_write}, 32'd0);
        chk("rst_full", {31'd0, pred_full}, 32'd0);
        chk("rst_qerr", {31'd0, qerr}, 32'd0);
        chk("rst_flush_pc", {16'd0, flush_pc}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Correct taken prediction
        push(16'd10, 1'b1, 16'd40);
        exp_out(1'b0, 16'd0, 1'b1, 16'd10, 16'd40, upd(16'd10, 1'b1));
        pop(1'b1, 1'b1, 16'd40);

        // Direction miss discards younger entries
        push(16'd20, 1'b0, 16'd0);
        push(16'd21, 1'b0, 16'd0);
        push(16'd22, 1'b0, 16'd0);
        exp_out(1'b1, 16'd5, 1'b1, 16'd20, 16'd5, upd(16'd20, 1'b1));
        pop(1'b1, 1'b1, 16'd5);
        push(16'd20, 1'b0, 16'd0);
        exp_out(1'b1, 16'd5, 1'b1, 16'd20, 16'd5, upd(16'd20, 1'b1));
        pop(1'b1, 1'b1, 16'd5);

        // Aliased non-branch entry, then a clean non-branch
        push(16'd30, 1'b1, 16'd99);
        exp_out(1'b1, 16'd31, 1'b1, 16'd30, 16'd99, 1'b0);
        pop(1'b0, 1'b0, 16'd0);
        push(16'd31, 1'b0, 16'd7);
        exp_out(1'b0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b0);
        pop(1'b0, 1'b0, 16'd0);

        // Correct not-taken, target mismatch, predicted-taken-but-not-taken
        push(16'd40, 1'b0, 16'd0);
        exp_out(1'b0, 16'd0, 1'b1, 16'd40, 16'd0, upd(16'd40, 1'b0));
        pop(1'b1, 1'b0, 16'd0);
        push(16'd50, 1'b1, 16'd60);
        exp_out(1'b1, 16'd61, 1'b1, 16'd50, 16'd61, upd(16'd50, 1'b1));
        pop(1'b1, 1'b1, 16'd61);
        push(16'd51, 1'b1, 16'd70);
        exp_out(1'b1, 16'd52, 1'b1, 16'd51, 16'd70, upd(16'd51, 1'b0));
        pop(1'b1, 1'b0, 16'd0);

        // Fill, overflow, then streaming push+pop across pointer wrap
        for (int i = 0; i < 8; i++) push(16'(100 + i), 1'b1, 16'(105 + i));
        chk("full_after_8", {31'd0, pred_full}, 32'd1);
        chk("qerr_before_ovf", {31'd0, qerr}, 32'd0);
        push(16'd200, 1'b1, 16'd205);
        chk("qerr_ovf", {31'd0, qerr}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            exp_out(1'b0, 16'd0, 1'b1, 16'(100 + i), 16'(105 + i), upd(16'(100 + i), 1'b1));
            cyc_in(1'b1, 16'(108 + i), 1'b1, 16'(113 + i), 1'b1, 1'b1, 1'b1, 16'(105 + i));
            if (i % 5 == 4) chk("full_stream", {31'd0, pred_full}, 32'd1);
        end
        for (int i = 20; i < 28; i++) begin
            exp_out(1'b0, 16'd0, 1'b1, 16'(100 + i), 16'(105 + i), upd(16'(100 + i), 1'b1));
            pop(1'b1, 1'b1, 16'(105 + i));
        end
        chk("full_drained", {31'd0, pred_full}, 32'd0);

        // Saturate down, then flush with a same-cycle push that must be lost
        for (int i = 0; i < 5; i++) begin
            push(16'd7, 1'b0, 16'd0);
            exp_out(1'b0, 16'd0, 1'b1, 16'd7, 16'd0, upd(16'd7, 1'b0));
            pop(1'b1, 1'b0, 16'd0);
        end
        push(16'd7, 1'b1, 16'd9);
        exp_out(1'b1, 16'd8, 1'b1, 16'd7, 16'd9, upd(16'd7, 1'b0));
        cyc_in(1'b1, 16'd8, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 16'd0);
        push(16'd60, 1'b0, 16'd0);
        exp_out(1'b0, 16'd0, 1'b1, 16'd60, 16'd0, upd(16'd60, 1'b0));
        pop(1'b1, 1'b0, 16'd0);

        // Reset mid-flight with entries queued
        push(16'd1, 1'b1, 16'd2);
        push(16'd2, 1'b1, 16'd3);
        push(16'd3, 1'b1, 16'd4);
        reset = 1'b0;
        #2;
        chk("midrst_qerr", {31'd0, qerr}, 32'd0);
        chk("midrst_full", {31'd0, pred_full}, 32'd0);
        chk("midrst_lut_write", {31'd0, lut_write}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) ctr_m[i] = 2'd1;
        exp_out(1'b0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b0);
        pop(1'b1, 1'b1, 16'd5);
        chk("qerr_empty_pop", {31'd0, qerr}, 32'd1);
        push(16'd7, 1'b0, 16'd0);
        exp_out(1'b1, 16'd3, 1'b1, 16'd7, 16'd3, upd(16'd7, 1'b1));
        pop(1'b1, 1'b1, 16'd3);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
